// File: rtl/amms_stream_bridge_pkg.sv
// Register map, STATUS bit positions and helpers shared by the Avalon-MM / stream bridge.
// Optional interrupt logic in the top is enabled by defining AMMS_STREAM_BRIDGE_IRQ_EN.
package amms_stream_bridge_pkg;

    localparam logic [1:0] ADDR_TX_DATA = 2'd0;
    localparam logic [1:0] ADDR_RX_DATA = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN  = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_UDF      = 5;
    localparam int ST_TX_LVL   = 8;
    localparam int ST_RX_LVL   = 16;

    localparam int IRQ_EN_W = 3;

    // A 256-deep FIFO reports 256 when full, which does not fit the 8-bit field; clamp it.
    function automatic logic [7:0] level_field(input logic [8:0] lvl);
        return lvl[8] ? 8'hFF : lvl[7:0];
    endfunction

endpackage

// File: rtl/amms_bridge_fifo.sv
// Single-clock FIFO with registered level; full/empty derive from the level only,
// so a pop in the same cycle never makes room for a push into a full FIFO.
module amms_bridge_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset: resetting the pointers is enough to discard every entry.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/amms_stream_bridge.sv
// Avalon-MM slave bridging HPS register accesses to a TX and an RX valid/ready stream.
// Define AMMS_STREAM_BRIDGE_IRQ_EN to enable the IRQ_EN register and the irq output.
module amms_stream_bridge
    import amms_stream_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]     tx_level, rx_level;
    logic [DATA_W-1:0] rx_head;
    logic              wr_tx, wr_status, rd_rx;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic              run_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       status_w;
    logic [IRQ_EN_W-1:0] irq_en_rd;

    assign wr_tx     = avs_write && (avs_address == ADDR_TX_DATA);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign rd_rx     = avs_read  && (avs_address == ADDR_RX_DATA);

    assign tx_push  = wr_tx && !tx_full;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    // run_q keeps rx_ready low until the first clock after reset release.
    assign rx_ready = run_q && !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = rd_rx && !rx_empty;

    amms_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_push),
        .wdata_i (avs_writedata),
        .pop_i   (tx_pop),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    amms_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (rx_push),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

    always_comb begin
        status_w              = '0;
        status_w[ST_TX_FULL]  = tx_full;
        status_w[ST_TX_EMPTY] = tx_empty;
        status_w[ST_RX_FULL]  = rx_full;
        status_w[ST_RX_EMPTY] = rx_empty;
        status_w[ST_OVF]      = ovf_q;
        status_w[ST_UDF]      = udf_q;
        status_w[ST_TX_LVL +: 8] = level_field(9'(tx_level));
        status_w[ST_RX_LVL +: 8] = level_field(9'(rx_level));
    end

    // Sticky flags: a new event in the same cycle as a W1C wins over the clear.
    always_comb begin
        ovf_d = (wr_tx && tx_full) || (ovf_q && !(wr_status && avs_writedata[ST_OVF]));
        udf_d = (rd_rx && rx_empty) || (udf_q && !(wr_status && avs_writedata[ST_UDF]));
    end

    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_RX_DATA: if (!rx_empty) rdata_d = rx_head;
                ADDR_STATUS:  rdata_d = DATA_W'(status_w);
                ADDR_IRQ_EN:  rdata_d = DATA_W'(irq_en_rd);
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            run_q   <= 1'b1;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;

`ifdef AMMS_STREAM_BRIDGE_IRQ_EN
    logic [IRQ_EN_W-1:0] irq_en_q, irq_en_d;
    logic                irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (avs_write && (avs_address == ADDR_IRQ_EN)) irq_en_d = avs_writedata[IRQ_EN_W-1:0];
        irq_d = (irq_en_q[0] && !rx_empty) || (irq_en_q[1] && tx_empty) ||
                (irq_en_q[2] && (ovf_q || udf_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = '0;
`endif

endmodule

// File: tb/tb_amms_stream_bridge.sv
// Scoreboard bench for amms_stream_bridge: directed register/stream traffic with queued expectations.
module tb_amms_stream_bridge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
`ifdef AMMS_STREAM_BRIDGE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [1:0]        avs_address = '0;
    logic              avs_write = 1'b0;
    logic              avs_read = 1'b0;
    logic [DATA_W-1:0] avs_writedata = '0;
    logic [DATA_W-1:0] avs_readdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              irq;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DATA_W-1:0] tx_q [$];
    logic [DATA_W-1:0] rd_q [$];

    amms_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [1:0] addr, input logic [DATA_W-1:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic avs_rd(input logic [1:0] addr, input logic [DATA_W-1:0] exp);
        avs_address = addr;
        avs_read    = 1'b1;
        rd_q.push_back(exp);
        tick();
        avs_read    = 1'b0;
    endtask

    task automatic tx_wr(input logic [DATA_W-1:0] data, input bit accepted);
        if (accepted) tx_q.push_back(data);
        avs_wr(2'd0, data);
    endtask

    // Monitor: reads complete one cycle after the strobe; stream beats when valid && ready.
    initial begin : monitor
        bit rd_pend;
        logic [DATA_W-1:0] exp_w;
        rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    exp_w = rd_q.pop_front();
                    check("avs_readdata", avs_readdata, exp_w);
                end
            end
            rd_pend = avs_read;
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) check("tx_unexpected_beat", 1, 0);
                else begin
                    exp_w = tx_q.pop_front();
                    check("tx_data", tx_data, exp_w);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        // Reset state
        #1 reset_n = 1'b0;
        repeat (2) tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_readdata", avs_readdata, 0);
        check("rst_irq", irq, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("post_rst_rx_ready", rx_ready, 1);
        check("post_rst_tx_valid", tx_valid, 0);
        avs_rd(2'd2, 32'h0000_000A);

        // Three TX writes streamed out in order, back-to-back push/pop
        tx_ready = 1'b1;
        tx_wr(32'hA, 1);
        tx_wr(32'hB, 1);
        tx_wr(32'hC, 1);
        repeat (3) tick();
        avs_rd(2'd2, 32'h0000_000A);
        avs_rd(2'd0, 32'h0);

        // TX overflow and W1C of ovf
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) tx_wr(32'h100 + i, i < DEPTH);
        avs_rd(2'd2, 32'h0000_1019);
        avs_wr(2'd2, 32'h10);
        avs_rd(2'd2, 32'h0000_1009);
        tx_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        tx_ready = 1'b0;
        avs_rd(2'd2, 32'h0000_000A);

        // RX single word, then underflow
        check("rx_ready_idle", rx_ready, 1);
        rx_data = 32'h55; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        avs_rd(2'd1, 32'h55);
        avs_rd(2'd1, 32'h0);
        avs_rd(2'd2, 32'h0000_002A);
        avs_wr(2'd2, 32'h20);
        avs_wr(2'd1, 32'hDEAD);
        avs_rd(2'd2, 32'h0000_000A);

        // RX full with a simultaneous pop: the offered word is not taken that cycle
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 32'h200 + i;
            tick();
        end
        rx_data = 32'h2FF;
        check("rx_ready_full", rx_ready, 0);
        avs_rd(2'd1, 32'h200);
        rx_valid = 1'b0;
        avs_rd(2'd2, 32'h000F_0002);
        for (int i = 1; i < DEPTH; i++) avs_rd(2'd1, 32'h200 + i);
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        avs_rd(2'd1, 32'h2FF);
        avs_rd(2'd2, 32'h0000_000A);

        // Interrupt on RX not empty
        avs_wr(2'd3, 32'h1);
        avs_rd(2'd3, IRQ_ON ? 32'h1 : 32'h0);
        check("irq_idle", irq, 0);
        rx_data = 32'h77; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("irq_same_cycle", irq, 0);
        tick();
        check("irq_after_push", irq, IRQ_ON);
        avs_rd(2'd1, 32'h77);
        tick();
        check("irq_after_read", irq, 0);
        avs_wr(2'd3, 32'h0);

        // Reset with both FIFOs half full
        for (int i = 0; i < DEPTH / 2; i++) tx_wr(32'h300 + i, 0);
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) begin
            rx_data = 32'h400 + i;
            tick();
        end
        rx_valid = 1'b0;
        avs_rd(2'd2, 32'h0008_0800);
        tick();
        #2 reset_n = 1'b0;
        tick();
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_readdata", avs_readdata, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("mid_post_rst_tx_valid", tx_valid, 0);
        check("mid_post_rst_rx_ready", rx_ready, 1);
        avs_rd(2'd2, 32'h0000_000A);
        avs_rd(2'd3, 32'h0);
        avs_rd(2'd1, 32'h0);
        tx_ready = 1'b1;
        repeat (4) tick();

        guard = 0;
        while ((tx_q.size() != 0 || rd_q.size() != 0) && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        check("tx_queue_drained", tx_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/amms_stream_bridge.md
AMMS_STREAM_BRIDGE -- requirements
Module: amms_stream_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of data registers and stream data; legal values 32, 64, 128.
REQ-002 SHALL have parameter DEPTH, default 16, meaning entries per direction FIFO; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port avs_address  input  2  Avalon-MM slave word address.
REQ-006 SHALL have ports avs_write and avs_read  input  1 each  Avalon-MM strobes.
REQ-007 SHALL have port avs_writedata  input  DATA_W  Avalon-MM write data.
REQ-008 SHALL have port avs_readdata  output  DATA_W  read data, fixed read latency 1.
REQ-009 SHALL have ports tx_data, tx_valid, tx_ready  output, output, input  DATA_W, 1, 1  to-FPGA stream.
REQ-010 SHALL have ports rx_data, rx_valid, rx_ready  input, input, output  DATA_W, 1, 1  from-FPGA stream.
REQ-011 SHALL have port irq  output  1  level interrupt to HPS.

Function
REQ-012 SHALL decode registers: 0 TX_DATA (W), 1 RX_DATA (R), 2 STATUS (R/W1C), 3 IRQ_EN (R/W).
REQ-013 SHALL push avs_writedata into TX FIFO on write to address 0 when TX FIFO not full.
REQ-014 SHALL drop a TX write when full; set STATUS.ovf (bit 4), sticky.
REQ-015 SHALL evaluate full/empty from registered counts; a simultaneous pop does not make room for the push.
REQ-016 SHALL drive tx_valid = TX not empty and tx_data = TX head, combinationally from FIFO state; pop when tx_valid && tx_ready.
REQ-017 SHALL drive rx_ready = RX not full; push rx_data when rx_valid && rx_ready.
REQ-018 SHALL pop the RX FIFO on read of address 0x1 when not empty; readdata = popped word next cycle.
REQ-019 SHALL return 0 on RX read when empty; set STATUS.udf (bit 5), sticky.
REQ-020 SHALL define STATUS: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 ovf, bit5 udf, [15:8] tx_level, [23:16] rx_level; other bits 0.
REQ-021 SHALL clear ovf/udf when 1 written to the bit; a same-cycle set takes priority over clear.
REQ-022 SHALL return 0 on reads of TX_DATA; writes to RX_DATA are ignored.
REQ-023 SHALL keep levels in log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-024 SHALL support simultaneous push and pop on the same FIFO in one cycle; level unchanged.

Reset
REQ-025 SHALL on reset_n low asynchronously empty both FIFOs, clear ovf, udf, IRQ_EN.
REQ-026 SHALL hold outputs at reset: avs_readdata 0, tx_valid 0, rx_ready 0 while reset_n low, irq 0; rx_ready 1 from first cycle after release.
REQ-027 SHALL discard in-flight transfers on reset mid-operation; no partial entries survive.

Configuration
REQ-028 SHALL with macro AMMS_STREAM_BRIDGE_IRQ_EN defined: irq = (IRQ_EN[0] & !rx_empty) | (IRQ_EN[1] & tx_empty) | (IRQ_EN[2] & (ovf|udf)), registered, one cycle latency.
REQ-029 SHALL without the macro: irq tied 0, IRQ_EN reads 0, writes ignored.

Structure
REQ-030 SHALL place register address constants and STATUS bit indices in package amms_stream_bridge_pkg.
REQ-031 SHALL implement each direction with sub-module amms_bridge_fifo (parameters DATA_W, DEPTH; push, pop, full, empty, level), instantiated twice.

Verification
REQ-032 SHALL cover: 3 writes 0xA,0xB,0xC to addr 0 with tx_ready=1 -> tx_data A,B,C on consecutive tx_valid cycles, tx_level returns 0.
REQ-033 SHALL cover: tx_ready=0, DEPTH+1 writes -> STATUS tx_full=1, ovf=1, tx_level=DEPTH; write 0x10 to STATUS -> ovf=0.
REQ-034 SHALL cover: rx_valid pushes 0x55 -> read addr 1 returns 0x55 next cycle; second read returns 0, udf=1.
REQ-035 SHALL cover: RX full with rx_valid=1 and simultaneous read -> rx_ready stays 0 that cycle, no data lost, rx_level=DEPTH-1 after.
REQ-036 SHALL cover (macro on): IRQ_EN=1, push one RX word -> irq=1 one cycle later; read it -> irq=0; macro off -> irq constant 0.
REQ-037 SHALL cover: reset_n low while both FIFOs half full -> STATUS reads 0x0000_000A after release, tx_valid=0.
